prm_edge_mask_engine: RTL and testbench

PRM_EDGE_MASK_ENGINE -- requirements
Module: prm_edge_mask_engine

---
 rtl/prm_edge_mask_engine.sv | 150 +++++++++++++++
 tb/tb_prm_edge_mask_engine.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_mask_engine.sv
// Sum-of-products obstacle matcher: ORs per-channel term hits across the beats of an edge set into one edge mask.
// Optional per-channel hit counters are built when PRM_HIT_CNT_EN is defined.
module prm_edge_mask_engine #(
    parameter int IN_W  = 15,
    parameter int TERMS = 16,
    parameter int CH    = 4,
    localparam int IDX_W = (TERMS > 1) ? $clog2(TERMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [IN_W-1:0]      cfg_care,
    input  logic [IN_W-1:0]      cfg_val,
    input  logic                 cfg_en,
    output logic                 cfg_err,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*IN_W-1:0]   in_word,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH-1:0]        out_mask
`ifdef PRM_HIT_CNT_EN
    ,
    output logic [CH*8-1:0]      hit_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [IDX_W:0] TERMS_L = TERMS[IDX_W:0];

    state_t            state;
    logic [CH-1:0]     acc;
    logic [CH-1:0]     hit;
    logic [CH-1:0]     acc_nxt;
    logic              cfg_ok;
    logic              accept;

    logic [TERMS-1:0]  term_en;
    logic [IN_W-1:0]   term_care [TERMS];
    logic [IN_W-1:0]   term_val  [TERMS];

    // The table may only change while no beat can be in flight, so a set never sees a mixed table.
    assign cfg_ok   = cfg_we && (state == IDLE) && !in_valid && ({1'b0, cfg_idx} < TERMS_L);
    assign in_ready = (state != HOLD);
    assign accept   = in_valid && in_ready;
    assign acc_nxt  = ((state == ACCUM) ? acc : '0) | hit;

    always_comb begin
        hit = '0;
        for (int c = 0; c < CH; c++) begin
            for (int t = 0; t < TERMS; t++) begin
                if (term_en[t] &&
                    (((in_word[c*IN_W +: IN_W] ^ term_val[t]) & term_care[t]) == '0)) begin
                    hit[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            term_en <= '0;
        end else if (cfg_ok) begin
            term_en[cfg_idx] <= cfg_en;
        end
    end

    // Literal storage is qualified by term_en, so it needs no reset.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            term_care[cfg_idx] <= cfg_care;
            term_val[cfg_idx]  <= cfg_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            out_mask  <= '0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            case (state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        if (in_last) begin
                            out_mask  <= acc_nxt;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            state     <= HOLD;
                        end else begin
                            acc   <= acc_nxt;
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PRM_HIT_CNT_EN
    logic [7:0] cnt     [CH];
    logic [7:0] cnt_nxt [CH];

    // The first beat of a set starts from zero; later beats saturate at 255.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            cnt_nxt[c] = (state == ACCUM)
                       ? cnt[c] + {7'd0, (hit[c] && (cnt[c] != 8'hff))}
                       : {7'd0, hit[c]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt <= '0;
            for (int c = 0; c < CH; c++) begin
                cnt[c] <= 8'd0;
            end
        end else if (accept) begin
            for (int c = 0; c < CH; c++) begin
                cnt[c] <= in_last ? 8'd0 : cnt_nxt[c];
                if (in_last) begin
                    hit_cnt[c*8 +: 8] <= cnt_nxt[c];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Directed self-checking bench for prm_edge_mask_engine; hit counter checks run when PRM_HIT_CNT_EN is defined.
module tb_prm_edge_mask_engine;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [14:0] cfg_care;
    logic [14:0] cfg_val;
    logic        cfg_en;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [59:0] in_word;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_mask;
`ifdef PRM_HIT_CNT_EN
    logic [31:0] hit_cnt;
`endif

    int checks = 0;
    int errors = 0;

    prm_edge_mask_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_care  (cfg_care),
        .cfg_val   (cfg_val),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask)
`ifdef PRM_HIT_CNT_EN
        ,
        .hit_cnt   (hit_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [59:0] words(input logic [14:0] w0, input logic [14:0] w1,
                                          input logic [14:0] w2, input logic [14:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic write_term(input logic [3:0] idx, input logic [14:0] care,
                              input logic [14:0] val, input logic en);
        cfg_we = 1'b1; cfg_idx = idx; cfg_care = care; cfg_val = val; cfg_en = en;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic send_beat(input logic [59:0] w, input logic last);
        in_valid = 1'b1; in_word = w; in_last = last;
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cfg_we = 0; cfg_idx = 0; cfg_care = 0; cfg_val = 0; cfg_en = 0;
        in_valid = 0; in_word = '0; in_last = 0; out_ready = 0;
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_mask !== 4'b0000) begin errors++; $display("FAIL reset_out_mask: got %b expected 0000", out_mask); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    endtask

    task automatic test_single_beat();
        write_term(4'd0, 15'h0003, 15'h0001, 1'b1);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL write_ok_err: got %b expected 0", cfg_err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %b expected 0", out_valid); end
        send_beat(words(15'h0001, 15'h0002, 15'h0000, 15'h0000), 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_mask !== 4'b0001) begin errors++; $display("FAIL single_mask: got %b expected 0001", out_mask); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready: got %b expected 0", in_ready); end
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_hold();
        send_beat(words(15'h0002, 15'h0002, 15'h0000, 15'h0002), 1'b0);
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL accum_bubble: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); end
        send_beat(words(15'h0002, 15'h0002, 15'h0005, 15'h0002), 1'b0);
        send_beat(words(15'h0002, 15'h0002, 15'h0002, 15'h0002), 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_mask !== 4'b0100 || in_ready !== 1'b0) begin errors++;
                $display("FAIL hold_stable[%0d]: got valid=%b mask=%b ready=%b expected 1 0100 0", i, out_valid, out_mask, in_ready); end
            in_valid = 1'b1; in_word = words(15'h0001, 15'h0001, 15'h0001, 15'h0001); in_last = 1'b1;
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_mask !== 4'b0100) begin errors++; $display("FAIL hold_after: got %b expected 0100", out_mask); end
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", out_valid); end
    endtask

    task automatic test_cfg_reject();
        send_beat(words(15'h0001, 15'h0002, 15'h0002, 15'h0002), 1'b0);
        write_term(4'd0, 15'h0000, 15'h0000, 1'b1);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL reject_accum_err: got %b expected 1", cfg_err); end
        step();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reject_pulse_len: got %b expected 0", cfg_err); end
        send_beat(words(15'h0002, 15'h0002, 15'h0002, 15'h0002), 1'b1);
        checks++; if (out_mask !== 4'b0001) begin errors++; $display("FAIL reject_set_mask: got %b expected 0001", out_mask); end
        consume();
        send_beat(words(15'h0002, 15'h0002, 15'h0002, 15'h0002), 1'b1);
        checks++; if (out_mask !== 4'b0000) begin errors++; $display("FAIL reject_table_kept: got %b expected 0000", out_mask); end
        consume();
        // Write collides with an IDLE beat: must be dropped too.
        cfg_we = 1'b1; cfg_idx = 4'd1; cfg_care = 15'h0000; cfg_val = 15'h0000; cfg_en = 1'b1;
        send_beat(words(15'h0002, 15'h0002, 15'h0002, 15'h0002), 1'b1);
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL reject_idle_err: got %b expected 1", cfg_err); end
        consume();
        send_beat(words(15'h0002, 15'h0002, 15'h0002, 15'h0002), 1'b1);
        checks++; if (out_mask !== 4'b0000) begin errors++; $display("FAIL reject_idle_table: got %b expected 0000", out_mask); end
        consume();
    endtask

    task automatic test_reset_midset();
        send_beat(words(15'h0001, 15'h0002, 15'h0002, 15'h0002), 1'b0);
        send_beat(words(15'h0001, 15'h0002, 15'h0002, 15'h0002), 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL midreset_state: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
        send_beat(words(15'h0001, 15'h0001, 15'h0001, 15'h0001), 1'b1);
        checks++; if (out_mask !== 4'b0000) begin errors++; $display("FAIL midreset_terms_off: got %b expected 0000", out_mask); end
        consume();
        write_term(4'd0, 15'h0003, 15'h0001, 1'b1);
        send_beat(words(15'h0002, 15'h0002, 15'h0002, 15'h0002), 1'b1);
        checks++; if (out_mask !== 4'b0000) begin errors++; $display("FAIL midreset_nohit: got %b expected 0000", out_mask); end
        consume();
        send_beat(words(15'h0001, 15'h0002, 15'h0002, 15'h7ffd), 1'b1);
        checks++; if (out_mask !== 4'b1001) begin errors++; $display("FAIL midreset_hit: got %b expected 1001", out_mask); end
        consume();
    endtask

    task automatic test_disabled_terms();
        logic [59:0] pats [4];
        pats[0] = words(15'h0001, 15'h7fff, 15'h1234, 15'h0000);
        pats[1] = words(15'h5555, 15'h2aaa, 15'h0f0f, 15'h70f0);
        pats[2] = 60'hfedcba987654321;
        pats[3] = 60'h0123456789abcde;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_beat(pats[i], 1'b1);
            checks++; if (out_mask !== 4'b0000) begin errors++; $display("FAIL disabled_mask[%0d]: got %b expected 0000", i, out_mask); end
            consume();
        end
        write_term(4'd5, 15'h0000, 15'h1234, 1'b1);
        send_beat(pats[2], 1'b1);
        checks++; if (out_mask !== 4'b1111) begin errors++; $display("FAIL care_zero_mask: got %b expected 1111", out_mask); end
        consume();
        write_term(4'd5, 15'h0000, 15'h0000, 1'b0);
        send_beat(pats[1], 1'b1);
        checks++; if (out_mask !== 4'b0000) begin errors++; $display("FAIL term_disable_mask: got %b expected 0000", out_mask); end
        consume();
    endtask

    task automatic test_back_to_back();
        write_term(4'd15, 15'h7f00, 15'h1200, 1'b1);
        send_beat(words(15'h12ab, 15'h0000, 15'h0000, 15'h0000), 1'b0);
        send_beat(words(15'h0000, 15'h0000, 15'h0000, 15'h12cd), 1'b1);
        checks++; if (out_mask !== 4'b1001) begin errors++; $display("FAIL b2b_first: got %b expected 1001", out_mask); end
        consume();
        send_beat(words(15'h0000, 15'h1200, 15'h0000, 15'h0000), 1'b1);
        checks++; if (out_mask !== 4'b0010) begin errors++; $display("FAIL b2b_second: got %b expected 0010", out_mask); end
        consume();
    endtask

`ifdef PRM_HIT_CNT_EN
    task automatic test_hit_cnt();
        do_reset();
        write_term(4'd0, 15'h0003, 15'h0001, 1'b1);
        send_beat(words(15'h0001, 15'h0002, 15'h0002, 15'h0002), 1'b0);
        send_beat(words(15'h0002, 15'h0002, 15'h0002, 15'h0002), 1'b0);
        send_beat(words(15'h0001, 15'h0001, 15'h0002, 15'h0002), 1'b1);
        checks++; if (hit_cnt !== 32'h0000_0102) begin errors++; $display("FAIL cnt_small: got %h expected 00000102", hit_cnt); end
        consume();
        for (int i = 0; i < 299; i++) begin
            send_beat(words(15'h0002, 15'h0002, 15'h0002, 15'h0001), 1'b0);
        end
        send_beat(words(15'h0002, 15'h0002, 15'h0002, 15'h0001), 1'b1);
        checks++; if (hit_cnt !== 32'hff00_0000) begin errors++; $display("FAIL cnt_saturate: got %h expected ff000000", hit_cnt); end
        checks++; if (out_mask !== 4'b1000) begin errors++; $display("FAIL cnt_mask: got %b expected 1000", out_mask); end
        consume();
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_hold();
        test_cfg_reject();
        test_reset_midset();
        test_disabled_terms();
        test_back_to_back();
`ifdef PRM_HIT_CNT_EN
        test_hit_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
